exu_wb_arbiter: RTL

Shares the single EXU writeback port (exu_wb_data / exu_wb_rd_addr / exu_wb_rd_wr_en, consumed by the IDU1 register file and its forwarding paths) between the ALU, MUL, DIV and LSU result sources. Each source gets a one-entry holding buffer, so results that lose arbitration are kept, not dropped. One result retires per cycle, under round-robin or fixed priority with a same-register age override. Buffer occupancy is exported as a stall term for IDU1.

---
 rtl/exu_wb_arbiter_pkg.sv | 31 +++
 rtl/exu_wb_arbiter_skid_buf.sv | 39 +++
 rtl/exu_wb_arbiter.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/exu_wb_arbiter_pkg.sv
// exu_wb_arbiter_pkg: types and helpers shared by the EXU writeback arbiter.
//   wb_req_t   - one writeback result {valid, rd_addr, data, tag}
//   WB_REQ_*   - requester indices (ALU, MUL, DIV, LSU)
//   tag_older  - wrap-aware instr_tag age comparison
package exu_wb_arbiter_pkg;

  localparam int unsigned WB_XLEN    = 32;
  localparam int unsigned WB_TAG_W   = 8;
  localparam int unsigned WB_NUM_REQ = 4;

  localparam int unsigned WB_REQ_ALU = 0;
  localparam int unsigned WB_REQ_MUL = 1;
  localparam int unsigned WB_REQ_DIV = 2;
  localparam int unsigned WB_REQ_LSU = 3;

  typedef struct packed {
    logic                valid;
    logic [4:0]          rd_addr;
    logic [WB_XLEN-1:0]  data;
    logic [WB_TAG_W-1:0] tag;
  } wb_req_t;

  // a is older than b when (a - b) mod 2^TAG_W has its MSB set
  function automatic logic tag_older(input logic [WB_TAG_W-1:0] a,
                                     input logic [WB_TAG_W-1:0] b);
    logic [WB_TAG_W-1:0] diff;
    diff = a - b;
    return diff[WB_TAG_W-1];
  endfunction

endpackage

// File: rtl/exu_wb_arbiter_skid_buf.sv
// wb_skid_buf: one-entry holding buffer for a writeback source that lost
// arbitration.
//   clk, rstn  - clock, asynchronous active-low reset
//   capture_i  - load entry_i (entry_i.valid is expected high)
//   clear_i    - drop the held entry (it was granted)
//   entry_i    - result to hold
//   entry_o    - held result, entry_o.valid is the occupancy flag
//   valid_o    - occupancy
//   ready_o    - source may present a new result (~valid)
module wb_skid_buf
  import exu_wb_arbiter_pkg::*;
(
  input  logic    clk,
  input  logic    rstn,
  input  logic    capture_i,
  input  logic    clear_i,
  input  wb_req_t entry_i,
  output wb_req_t entry_o,
  output logic    valid_o,
  output logic    ready_o
);

  wb_req_t entry_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      entry_q <= '0;
    end else if (capture_i) begin
      entry_q <= entry_i;
    end else if (clear_i) begin
      entry_q.valid <= 1'b0;
    end
  end

  assign entry_o = entry_q;
  assign valid_o = entry_q.valid;
  assign ready_o = ~entry_q.valid;

endmodule

// File: rtl/exu_wb_arbiter.sv
// exu_wb_arbiter: shares the single EXU writeback port between ALU, MUL,
// DIV and LSU. Each source owns a one-entry holding buffer so results that
// lose arbitration are retained; one result retires per cycle.
//   clk, rstn          - clock, asynchronous active-low reset
//   req_valid          - per-source result valid            [NUM_REQ]
//   req_rd_addr        - per-source destination register    [NUM_REQ x 5]
//   req_data           - per-source result                  [NUM_REQ x XLEN]
//   req_tag            - per-source instr_tag               [NUM_REQ x TAG_W]
//   req_ready          - source may present a new result (~buf_valid)
//   exu_wb_rd_wr_en    - registered write enable
//   exu_wb_rd_addr     - registered destination register
//   exu_wb_data        - registered writeback data
//   exu_wb_instr_tag   - registered tag of the retired result
//   wb_arb_busy        - any holding buffer occupied (IDU1 stall term)
// Build option: WB_ARB_RR_EN selects round-robin priority; without it the
// highest index wins (LSU > DIV > MUL > ALU) and no pointer is built.
module exu_wb_arbiter
  import exu_wb_arbiter_pkg::*;
#(
  parameter int unsigned XLEN    = WB_XLEN,
  parameter int unsigned NUM_REQ = WB_NUM_REQ,
  parameter int unsigned TAG_W   = WB_TAG_W
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*5-1:0]     req_rd_addr,
  input  logic [NUM_REQ*XLEN-1:0]  req_data,
  input  logic [NUM_REQ*TAG_W-1:0] req_tag,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     exu_wb_rd_wr_en,
  output logic [4:0]               exu_wb_rd_addr,
  output logic [XLEN-1:0]          exu_wb_data,
  output logic [TAG_W-1:0]         exu_wb_instr_tag,
  output logic                     wb_arb_busy
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  wb_req_t              live  [NUM_REQ];
  wb_req_t              buf_q [NUM_REQ];
  wb_req_t              eff   [NUM_REQ];
  logic [NUM_REQ-1:0]   buf_valid;
  logic [NUM_REQ-1:0]   cand;
  logic [NUM_REQ-1:0]   elig;
  logic [NUM_REQ-1:0]   gnt;
  logic [NUM_REQ-1:0]   capture;
  logic [NUM_REQ-1:0]   clear;
  logic                 gnt_any;
  logic [IDX_W-1:0]     gnt_idx;

  logic                 wr_en_q;
  logic [4:0]           rd_q;
  logic [XLEN-1:0]      data_q;
  logic [TAG_W-1:0]     tag_q;

  // Effective request per source: the held entry if any, otherwise the live
  // input (only accepted while ready, i.e. while the buffer is empty).
  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      live[i].valid   = req_valid[i] & ~buf_valid[i];
      live[i].rd_addr = req_rd_addr[i*5 +: 5];
      live[i].data    = req_data[i*XLEN +: XLEN];
      live[i].tag     = req_tag[i*TAG_W +: TAG_W];
      eff[i]          = buf_valid[i] ? buf_q[i] : live[i];
      // x0 results are consumed on the spot and never compete
      cand[i]         = eff[i].valid & (|eff[i].rd_addr);
    end
  end

  // Same-register age override: an entry is masked while any other candidate
  // targeting the same register carries an older tag.
  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      elig[i] = cand[i];
      for (int unsigned j = 0; j < NUM_REQ; j++) begin
        if (j != i && cand[j] && eff[j].rd_addr == eff[i].rd_addr &&
            tag_older(eff[j].tag, eff[i].tag)) begin
          elig[i] = 1'b0;
        end
      end
    end
  end

`ifdef WB_ARB_RR_EN
  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] ptr_d;

  always_comb begin
    int unsigned idx;
    idx     = 0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr_q) + k) % NUM_REQ;
      if (!gnt_any && elig[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = IDX_W'(idx);
      end
    end
    ptr_d = ptr_q;
    if (gnt_any) begin
      ptr_d = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  // Ascending scan: a later (higher) index overrides, so the highest wins.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (elig[i]) begin
        gnt_any = 1'b1;
        gnt_idx = IDX_W'(i);
      end
    end
  end
`endif

  // Ungranted live non-x0 results are captured; granted held results clear.
  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      gnt[i]     = gnt_any && (gnt_idx == IDX_W'(i));
      capture[i] = live[i].valid & (|live[i].rd_addr) & ~gnt[i];
      clear[i]   = buf_valid[i] & gnt[i];
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_buf
    wb_skid_buf u_buf (
      .clk       (clk),
      .rstn      (rstn),
      .capture_i (capture[g]),
      .clear_i   (clear[g]),
      .entry_i   (live[g]),
      .entry_o   (buf_q[g]),
      .valid_o   (buf_valid[g]),
      .ready_o   (req_ready[g])
    );
  end

  // Payload registers hold their last value while no write is granted.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_en_q <= 1'b0;
      rd_q    <= '0;
      data_q  <= '0;
      tag_q   <= '0;
    end else begin
      wr_en_q <= gnt_any;
      if (gnt_any) begin
        rd_q   <= eff[gnt_idx].rd_addr;
        data_q <= eff[gnt_idx].data;
        tag_q  <= eff[gnt_idx].tag;
      end
    end
  end

  assign exu_wb_rd_wr_en  = wr_en_q;
  assign exu_wb_rd_addr   = rd_q;
  assign exu_wb_data      = data_q;
  assign exu_wb_instr_tag = tag_q;
  assign wb_arb_busy      = |buf_valid;

endmodule
